// File: rtl/uart_tx_framer.sv
// UART transmit framer: a small word FIFO feeding a start/data/parity/stop
// serializer. The tx, tx_busy and tx_done registers are driven from the
// state the FSM held before each edge. The line therefore trails the FSM
// by one cycle, so a word pushed into an empty idle FIFO first drives tx
// low two edges after it is pushed.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | line high; pop the FIFO head as soon as one is queued
// START  | start bit (low) for one bit time
// DATA   | DATA_BITS data bits, LSB first, one bit time each
// PARITY | even/odd parity bit for one bit time (skipped in mode 0)
// STOP   | line high for STOP_BITS bit times; may chain into START
module uart_tx_framer #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_BITS-1:0]          in_data,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          tx_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam int BAUD_MAX = STOP_BITS * CLKS_PER_BIT - 1;
    localparam int BW       = $clog2(BAUD_MAX + 1);
    localparam int NW       = $clog2(DATA_BITS);

    // The baud counter covers the longest interval, the whole stop period.
    localparam logic [BW-1:0] BIT_LOAD  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] STOP_LOAD = BW'(BAUD_MAX);
    localparam logic [NW-1:0] LAST_BIT  = NW'(DATA_BITS - 1);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
    localparam logic          PAR_INV   = (PARITY_MODE == 2);
    localparam logic          HAS_PAR   = (PARITY_MODE != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;

    state_t               state;
    state_t               state_next;
    logic [BW-1:0]        baud_cnt;
    logic [BW-1:0]        baud_next;
    logic [NW-1:0]        bit_cnt;
    logic [NW-1:0]        bit_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 par_bit;
    logic                 par_next;
    logic                 tx_next;
    logic                 busy_next;
    logic                 done_next;
    logic                 baud_tc;

    assign in_ready   = reset && (count != FULL);
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];
    assign baud_tc    = (baud_cnt == '0);
    assign fifo_count = count;

    // FIFO storage; a full FIFO never accepts, so nothing is overwritten.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; push and pop in one cycle cancel out.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Next-state, counter and line-level decode for the serializer.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        par_next   = par_bit;
        tx_next    = 1'b1;
        busy_next  = 1'b1;
        done_next  = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                    baud_next  = BIT_LOAD;
                    shift_next = head;
                    par_next   = (^head) ^ PAR_INV;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_tc) begin
                    state_next = DATA;
                    baud_next  = BIT_LOAD;
                    bit_next   = LAST_BIT;
                end else begin
                    baud_next = baud_cnt - BW'(1);
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (baud_tc) begin
                    shift_next = shift_reg >> 1;
                    if (bit_cnt == '0) begin
                        state_next = HAS_PAR ? PARITY : STOP;
                        baud_next  = HAS_PAR ? BIT_LOAD : STOP_LOAD;
                    end else begin
                        bit_next  = bit_cnt - NW'(1);
                        baud_next = BIT_LOAD;
                    end
                end else begin
                    baud_next = baud_cnt - BW'(1);
                end
            end
            PARITY: begin
                tx_next = par_bit;
                if (baud_tc) begin
                    state_next = STOP;
                    baud_next  = STOP_LOAD;
                end else begin
                    baud_next = baud_cnt - BW'(1);
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (baud_tc) begin
                    done_next = 1'b1;
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = START;
                        baud_next  = BIT_LOAD;
                        shift_next = head;
                        par_next   = (^head) ^ PAR_INV;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt - BW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
                busy_next  = 1'b0;
                baud_next  = '0;
                bit_next   = '0;
            end
        endcase
    end

    // State, counters and registered line outputs; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            par_bit   <= par_next;
            tx        <= tx_next;
            tx_busy   <= busy_next;
            tx_done   <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: three configurations driven from shared
// stimulus, each compared every cycle against a frame-level model.
module tb_uart_tx_framer;

    logic       clk;
    logic       reset;
    logic       vld;
    logic [7:0] din;

    logic       rdy_a, tx_a, busy_a, done_a;
    logic [2:0] cnt_a;
    logic       rdy_b, tx_b, busy_b, done_b;
    logic [2:0] cnt_b;
    logic       rdy_c, tx_c, busy_c, done_c;
    logic [1:0] cnt_c;

    // A: 8 data bits, even parity, 1 stop, 4 clk/bit, depth 4
    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(1),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(vld), .in_ready(rdy_a),
        .in_data(din), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a),
        .fifo_count(cnt_a));

    // B: 8 data bits, odd parity, 2 stops, 4 clk/bit, depth 4
    uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_MODE(2),
                     .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(vld), .in_ready(rdy_b),
        .in_data(din), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b),
        .fifo_count(cnt_b));

    // C: 7 data bits, no parity, 1 stop, 2 clk/bit, depth 2
    uart_tx_framer #(.DATA_BITS(7), .CLKS_PER_BIT(2), .PARITY_MODE(0),
                     .STOP_BITS(1), .FIFO_DEPTH(2)) dut_c (
        .clk(clk), .reset(reset), .in_valid(vld), .in_ready(rdy_c),
        .in_data(din[6:0]), .tx(tx_c), .tx_busy(busy_c), .tx_done(done_c),
        .fifo_count(cnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: queued words plus the frame currently on the line, expressed
    // as its bit pattern and the number of line cycles still to be sent.
    typedef struct packed {
        logic [3:0]      cnt;
        logic [7:0][8:0] w;
        logic [7:0]      lrem;
        logic [15:0]     fbits;
    } mdl_t;

    mdl_t ma, mb, mc;
    int total = 0;
    int bad   = 0;
    int bsy_a, bsy_b, bsy_c, dn_a, dn_b, acc_a, acc_c;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] build_frame(input logic [8:0] w,
                                                input int db, input int pm);
        logic [15:0] f;
        logic        p;
        f    = '1;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int i = 0; i < db; i++) begin
            f[1+i] = w[i];
            p      = p ^ w[i];
        end
        if (pm != 0) f[1+db] = (pm == 2) ? ~p : p;
        return f;
    endfunction

    function automatic logic exp_rdy(input mdl_t m, input int depth,
                                     input logic rst_n);
        return rst_n && (int'(m.cnt) < depth);
    endfunction

    task automatic model_step(input int db, input int cpb, input int pm,
                              input int sb, input int depth, input mdl_t mi,
                              input logic rst_n, input logic v,
                              input logic [8:0] d, output mdl_t mo,
                              output logic etx, output logic ebusy,
                              output logic edone);
        int         flen;
        logic [8:0] mask;
        flen = (1 + db + ((pm != 0) ? 1 : 0) + sb) * cpb;
        mask = 9'((1 << db) - 1);
        mo   = mi;
        etx  = 1'b1;
        ebusy = 1'b0;
        edone = 1'b0;
        if (!rst_n) begin
            mo = '0;
        end else begin
            ebusy = (mi.lrem != 0);
            edone = (mi.lrem == 1);
            if (mi.lrem != 0) begin
                etx     = mi.fbits[4'((flen - int'(mi.lrem)) / cpb)];
                mo.lrem = mi.lrem - 8'd1;
            end
            if (mi.lrem <= 1 && mi.cnt != 0) begin
                mo.fbits = build_frame(mi.w[0], db, pm);
                mo.lrem  = 8'(flen);
                for (int i = 0; i < 7; i++) mo.w[i] = mi.w[i+1];
                mo.cnt = mi.cnt - 4'd1;
            end
            if (v && (int'(mi.cnt) < depth)) begin
                mo.w[3'(mo.cnt)] = d & mask;
                mo.cnt = mo.cnt + 4'd1;
            end
        end
    endtask

    // One clock: check in_ready before the edge, advance the models on the
    // edge, then compare registered outputs just after it.
    task automatic step();
        mdl_t nx;
        logic etx, ebs, edn;
        #1;
        check("ready_a", rdy_a, exp_rdy(ma, 4, reset));
        check("ready_b", rdy_b, exp_rdy(mb, 4, reset));
        check("ready_c", rdy_c, exp_rdy(mc, 2, reset));
        if (vld && rdy_a) acc_a++;
        if (vld && rdy_c) acc_c++;
        @(posedge clk);
        model_step(8, 4, 1, 1, 4, ma, reset, vld, {1'b0, din}, nx, etx, ebs, edn);
        ma = nx;
        #1;
        check("tx_a", tx_a, etx);
        check("busy_a", busy_a, ebs);
        check("done_a", done_a, edn);
        check("count_a", cnt_a, ma.cnt);
        model_step(8, 4, 2, 2, 4, mb, reset, vld, {1'b0, din}, nx, etx, ebs, edn);
        mb = nx;
        check("tx_b", tx_b, etx);
        check("busy_b", busy_b, ebs);
        check("done_b", done_b, edn);
        check("count_b", cnt_b, mb.cnt);
        model_step(7, 2, 0, 1, 2, mc, reset, vld, {1'b0, din}, nx, etx, ebs, edn);
        mc = nx;
        check("tx_c", tx_c, etx);
        check("busy_c", busy_c, ebs);
        check("done_c", done_c, edn);
        check("count_c", cnt_c, mc.cnt);
        if (busy_a) bsy_a++;
        if (busy_b) bsy_b++;
        if (busy_c) bsy_c++;
        if (done_a) dn_a++;
        if (done_b) dn_b++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        repeat (n) step();
    endtask

    task automatic clear_stats();
        bsy_a = 0; bsy_b = 0; bsy_c = 0;
        dn_a = 0; dn_b = 0; acc_a = 0; acc_c = 0;
    endtask

    initial begin
        ma = '0; mb = '0; mc = '0;
        clear_stats();
        reset = 1'b0;
        vld   = 1'b0;
        din   = 8'h00;
        @(negedge clk);
        repeat (3) step();
        reset = 1'b1;

        // single word, frame lengths per configuration
        clear_stats();
        vld = 1'b1; din = 8'hA5; step();
        idle(70);
        check("len_a", bsy_a, 44);
        check("len_b", bsy_b, 48);
        check("len_c", bsy_c, 18);
        check("done_cnt_a", dn_a, 1);

        // parity of a single set bit
        vld = 1'b1; din = 8'h01; step();
        idle(70);

        // back-to-back words with two stop bits
        clear_stats();
        vld = 1'b1; din = 8'h3C; step();
        din = 8'hC3; step();
        idle(120);
        check("b2b_done_b", dn_b, 2);
        check("b2b_busy_b", bsy_b, 96);

        // continuous pushes until the FIFO fills
        clear_stats();
        vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = 8'(8'h10 + i);
            step();
        end
        vld = 1'b0;
        check("burst_acc_a", acc_a, 5);
        check("burst_acc_c", acc_c, 3);
        idle(300);
        check("burst_done_a", dn_a, 5);

        // reset in the middle of data bit 3 of 0xFF with two words queued
        vld = 1'b1; din = 8'hFF; step();
        din = 8'h11; step();
        din = 8'h22; step();
        idle(17);
        clear_stats();
        reset = 1'b0; step();
        reset = 1'b1;
        check("abort_count_a", cnt_a, 0);
        idle(150);
        check("abort_done_a", dn_a, 0);
        check("abort_busy_a", bsy_a, 0);

        // random traffic with varying load and occasional resets
        for (int seg = 0; seg < 8; seg++) begin
            int p;
            p = int'($urandom_range(5, 95));
            repeat (300) begin
                vld   = (int'($urandom_range(0, 99)) < p);
                din   = 8'($urandom);
                reset = ($urandom_range(0, 499) != 0);
                step();
            end
        end
        reset = 1'b1;
        idle(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 Parameter CLKS_PER_BIT, default 87, clk cycles per serial bit (legal >= 2).
REQ-003 Parameter PARITY_MODE, default 1, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-005 Parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of 2, >= 2).
REQ-006 clk  input  1  rising-edge clock for all logic.
REQ-007 reset  input  1  reset, synchronous, active-low.
REQ-008 in_valid  input  1  in_data is offered for queuing.
REQ-009 in_ready  output  1  FIFO can accept a word this cycle.
REQ-010 in_data  input  DATA_BITS  word to transmit.
REQ-011 tx  output  1  serial line, idle high, registered.
REQ-012 tx_busy  output  1  a frame is on the line (START through last STOP cycle).
REQ-013 tx_done  output  1  one-cycle pulse per completed frame.
REQ-014 fifo_count  output  clog2(FIFO_DEPTH)+1  words queued, not counting the word on the line.

Function
REQ-015 A push occurs on a rising edge with in_valid=1 and in_ready=1; the word is captured on that edge.
REQ-016 in_ready SHALL equal (fifo_count != FIFO_DEPTH) while reset=1, and SHALL be 0 while reset=0.
REQ-017 In-order FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: tx=1; if the FIFO is non-empty, pop the head into a shift register and enter START on the same edge.
REQ-019 START: tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-020 DATA: DATA_BITS bits LSB first, each held exactly CLKS_PER_BIT cycles, then PARITY if PARITY_MODE!=0, else STOP.
REQ-021 PARITY: tx = XOR of all data bits (mode 1) or its inverse (mode 2), held CLKS_PER_BIT cycles.
REQ-022 STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
REQ-023 Frame length = (1+DATA_BITS+(PARITY_MODE!=0)+STOP_BITS)*CLKS_PER_BIT cycles, with no jitter.
REQ-024 On the edge ending STOP: tx_done=1 for one cycle; if the FIFO is non-empty, pop and enter START directly (zero idle gap); else enter IDLE.
REQ-025 tx_busy=1 in START, DATA, PARITY and STOP; 0 in IDLE.
REQ-026 Latency: push into an empty FIFO while IDLE -> tx falls low 2 edges after the push edge.
REQ-027 Simultaneous push and pop: both take effect; fifo_count is unchanged.
REQ-028 Full FIFO: in_ready=0 and in_valid is ignored; data is never overwritten.
REQ-029 Empty FIFO: no pop occurs; the FSM stays in IDLE.
REQ-030 FIFO pointers wrap modulo FIFO_DEPTH; fifo_count saturates at 0 and at FIFO_DEPTH.
REQ-031 Bit and baud counters are sized for their maxima and never wrap within a bit.
REQ-032 An unreachable FSM encoding SHALL return to IDLE with tx=1 on the next edge.

Reset
REQ-033 While reset=0 at an edge: state=IDLE, tx=1, tx_busy=0, tx_done=0, FIFO emptied, fifo_count=0, counters=0.
REQ-034 Reset mid-frame aborts the frame: tx=1 on the same edge, no tx_done pulse, and all queued words are discarded.
REQ-035 Pushes are ignored while reset=0; the first push can occur on the first edge with reset=1.

Verification (DATA_BITS=8, CLKS_PER_BIT=4, FIFO_DEPTH=4 unless stated)
REQ-036 PARITY_MODE=1, STOP_BITS=1, push 0xA5 -> tx per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 0, 1; frame is 44 cycles; one tx_done pulse.
REQ-037 PARITY_MODE=2, push 0x01 -> parity bit 0; PARITY_MODE=1, push 0x01 -> parity bit 1; PARITY_MODE=0 -> frame is 40 cycles.
REQ-038 STOP_BITS=2, push 0x3C then 0xC3 back-to-back -> stop high for 8 cycles, second start bit follows immediately, tx_busy never drops, and tx_done pulses twice.
REQ-039 Push 6 words continuously -> in_ready drops once fifo_count=4 with one word on the line; the extra word is not accepted; all accepted words are sent in order.
REQ-040 Assert reset during the DATA bit 3 of 0xFF with 2 words queued -> tx=1 on the next edge, fifo_count=0, no tx_done pulse, and no further frames.
REQ-041 DATA_BITS=7, PARITY_MODE=0, push 0x55 -> 7 data bits 1,0,1,0,1,0,1 then stop; frame is 36 cycles.
